en_burst_monitor: RTL and testbench

- Downstream consumer of the enable-burst generator stage.
- Samples its `en` output and measures each high burst (length in cycles) and the low gap that follows.
- Publishes one record per burst/gap pair over a valid/ack handshake, flagging deviations from the expected burst shape.
- Used as an on-chip checker: feeds a status register/LED path and catches enable-timing regressions in hardware.

---
 rtl/en_burst_monitor_if.sv | 25 ++
 rtl/en_burst_monitor.sv | 137 +++++++++++++
 tb/tb_en_burst_monitor.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/en_burst_monitor_if.sv
// Result bus of the enable-burst monitor: one record per burst/gap pair with a valid/ack handshake.
// The monitor drives the record through the master modport; the consumer acks through the slave modport.
interface en_burst_monitor_if #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
);
  logic             res_valid;
  logic             res_ack;
  logic [LEN_W-1:0] res_len;
  logic [LEN_W-1:0] res_gap;
  logic             len_err;
  logic             gap_err;
  logic             overrun;
  logic [CNT_W-1:0] rec_cnt;

  modport master (
    input  res_ack,
    output res_valid, res_len, res_gap, len_err, gap_err, overrun, rec_cnt
  );

  modport slave (
    output res_ack,
    input  res_valid, res_len, res_gap, len_err, gap_err, overrun, rec_cnt
  );
endinterface

// File: rtl/en_burst_monitor.sv
// Measures each en_in high burst and the gap after it, publishing one flagged record per pair.
// Define GAP_CHECK_EN to compare the gap against EXP_GAP; otherwise gap_err is tied low.
module en_burst_monitor #(
  parameter int LEN_W   = 4,
  parameter int EXP_LEN = 9,
  parameter int EXP_GAP = 2,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_in,
  en_burst_monitor_if.master   res
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  typedef enum logic [1:0] {S_SYNC, S_WAIT, S_HIGH, S_LOW} state_t;

  state_t           state_q,   state_d;
  logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
  logic [LEN_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             valid_q,   valid_d;
  logic [LEN_W-1:0] res_len_q, res_len_d;
  logic [LEN_W-1:0] res_gap_q, res_gap_d;
  logic             len_err_q, len_err_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] rec_cnt_q, rec_cnt_d;
  logic             publish;

  // A record is only published on the rising edge that ends a complete gap.
  always_comb begin
    state_d   = state_q;
    len_cnt_d = len_cnt_q;
    gap_cnt_d = gap_cnt_q;
    publish   = 1'b0;
    unique case (state_q)
      S_SYNC: begin
        if (!en_in) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (en_in) begin
          state_d   = S_HIGH;
          len_cnt_d = LEN_W'(1);
        end
      end
      S_HIGH: begin
        if (en_in) begin
          if (len_cnt_q != LEN_MAX) len_cnt_d = len_cnt_q + 1'b1;
        end else begin
          state_d   = S_LOW;
          gap_cnt_d = LEN_W'(1);
        end
      end
      S_LOW: begin
        if (!en_in) begin
          if (gap_cnt_q != LEN_MAX) gap_cnt_d = gap_cnt_q + 1'b1;
        end else begin
          publish   = 1'b1;
          state_d   = S_HIGH;
          len_cnt_d = LEN_W'(1);
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  // Overrun is set when an unacked record is replaced, and cleared only by an ack.
  always_comb begin
    valid_d   = valid_q;
    res_len_d = res_len_q;
    res_gap_d = res_gap_q;
    len_err_d = len_err_q;
    overrun_d = overrun_q;
    rec_cnt_d = rec_cnt_q;
    if (publish) begin
      valid_d   = 1'b1;
      res_len_d = len_cnt_q;
      res_gap_d = gap_cnt_q;
      len_err_d = (len_cnt_q != LEN_W'(EXP_LEN));
      rec_cnt_d = rec_cnt_q + 1'b1;
      if (valid_q) overrun_d = !res.res_ack;
    end else if (valid_q && res.res_ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_SYNC;
      len_cnt_q <= '0;
      gap_cnt_q <= '0;
      valid_q   <= 1'b0;
      res_len_q <= '0;
      res_gap_q <= '0;
      len_err_q <= 1'b0;
      overrun_q <= 1'b0;
      rec_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      len_cnt_q <= len_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      valid_q   <= valid_d;
      res_len_q <= res_len_d;
      res_gap_q <= res_gap_d;
      len_err_q <= len_err_d;
      overrun_q <= overrun_d;
      rec_cnt_q <= rec_cnt_d;
    end
  end

`ifdef GAP_CHECK_EN
  logic gap_err_q, gap_err_d;

  always_comb begin
    gap_err_d = gap_err_q;
    if (publish) gap_err_d = (gap_cnt_q != LEN_W'(EXP_GAP));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap_err_q <= 1'b0;
    else        gap_err_q <= gap_err_d;
  end

  assign res.gap_err = gap_err_q;
`else
  assign res.gap_err = 1'b0;
`endif

  assign res.res_valid = valid_q;
  assign res.res_len   = res_len_q;
  assign res.res_gap   = res_gap_q;
  assign res.len_err   = len_err_q;
  assign res.overrun   = overrun_q;
  assign res.rec_cnt   = rec_cnt_q;

endmodule

// File: tb/tb_en_burst_monitor.sv
// Randomized bench for en_burst_monitor: bursts are generated as (high, low) pairs and the
// expected records are derived from those pairs, then matched by an independent monitor.
module tb_en_burst_monitor;

  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int EXP_LEN = 9;
  localparam int EXP_GAP = 2;
  localparam int LEN_MAX = (1 << LEN_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en_in = 1'b1;

  en_burst_monitor_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  en_burst_monitor #(
    .LEN_W(LEN_W), .EXP_LEN(EXP_LEN), .EXP_GAP(EXP_GAP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en_in(en_in),
    .res(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int gap;
    bit len_err;
    bit gap_err;
    int cnt;
  } rec_t;

  typedef struct {
    bit valid;
    bit overrun;
  } cyc_t;

  rec_t exp_rec[$];
  cyc_t exp_cyc[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_valid;
  bit   m_overrun;
  int   m_cnt;

  function automatic void checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endfunction

  function automatic int sat(input int v);
    return (v > LEN_MAX) ? LEN_MAX : v;
  endfunction

  // One clock of stimulus; pub marks the first high cycle after a complete burst/gap pair.
  task automatic applyStimulus(input bit en, input bit pub, input int plen, input int pgap,
                               input int ack_pct, input bit ack_on_pub);
    bit   ack;
    rec_t r;
    @(negedge clk);
    ack = ack_on_pub ? pub : ($urandom_range(99) < ack_pct);
    en_in       = en;
    bus.res_ack = ack;
    if (pub) begin
      r.len     = sat(plen);
      r.gap     = sat(pgap);
      r.len_err = (r.len != EXP_LEN);
`ifdef GAP_CHECK_EN
      r.gap_err = (r.gap != EXP_GAP);
`else
      r.gap_err = 1'b0;
`endif
      if (m_valid) m_overrun = !ack;
      m_valid = 1'b1;
      m_cnt   = (m_cnt + 1) % (1 << CNT_W);
      r.cnt   = m_cnt;
      exp_rec.push_back(r);
    end else if (ack && m_valid) begin
      m_valid   = 1'b0;
      m_overrun = 1'b0;
    end
    exp_cyc.push_back('{m_valid, m_overrun});
  endtask

  // Reset is asserted between clock edges, so the outputs must clear without waiting for clk.
  task automatic doReset();
    @(negedge clk);
    #2;
    checkOutput("records_drained", exp_rec.size(), 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_res_valid", bus.res_valid, 0);
    checkOutput("rst_res_len",   bus.res_len,   0);
    checkOutput("rst_res_gap",   bus.res_gap,   0);
    checkOutput("rst_len_err",   bus.len_err,   0);
    checkOutput("rst_gap_err",   bus.gap_err,   0);
    checkOutput("rst_overrun",   bus.overrun,   0);
    checkOutput("rst_rec_cnt",   bus.rec_cnt,   0);
    m_valid   = 1'b0;
    m_overrun = 1'b0;
    m_cnt     = 0;
    exp_rec.delete();
    exp_cyc.delete();
    en_in       = 1'b1;
    bus.res_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode: 0 = 9/2, 1 = 5/2, 2 = random, 3 = 20/3; cut > 0 leaves a trailing burst of cut highs.
  task automatic runPhase(input int prefix, input int low, input int mode, input int nb,
                          input int cut, input int ack_pct, input bit ack_on_pub);
    int h, g, ph, pg;
    doReset();
    repeat (prefix) applyStimulus(1'b1, 1'b0, 0, 0, ack_pct, ack_on_pub);
    repeat (low)    applyStimulus(1'b0, 1'b0, 0, 0, ack_pct, ack_on_pub);
    ph = 0;
    pg = 0;
    for (int b = 0; b < nb; b++) begin
      case (mode)
        0:       begin h = 9;  g = 2; end
        1:       begin h = 5;  g = 2; end
        3:       begin h = 20; g = 3; end
        default: begin h = $urandom_range(20, 1); g = $urandom_range(5, 1); end
      endcase
      for (int i = 0; i < h; i++)
        applyStimulus(1'b1, (i == 0) && (b > 0), ph, pg, ack_pct, ack_on_pub);
      for (int i = 0; i < g; i++)
        applyStimulus(1'b0, 1'b0, 0, 0, ack_pct, ack_on_pub);
      ph = h;
      pg = g;
    end
    for (int i = 0; i < cut; i++)
      applyStimulus(1'b1, (i == 0) && (nb > 0), ph, pg, ack_pct, ack_on_pub);
  endtask

  // Monitor: per-cycle handshake state, plus one record popped per rec_cnt change.
  initial begin : monitor
    cyc_t c;
    rec_t r;
    int   prev_cnt;
    prev_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_cyc.size() > 0) begin
        c = exp_cyc.pop_front();
        checkOutput("res_valid", bus.res_valid, c.valid);
        checkOutput("overrun",   bus.overrun,   c.overrun);
      end
      if (!rst_n) begin
        prev_cnt = 0;
      end else if (int'(bus.rec_cnt) != prev_cnt) begin
        prev_cnt = bus.rec_cnt;
        checkOutput("publish_expected", exp_rec.size() > 0, 1);
        if (exp_rec.size() > 0) begin
          r = exp_rec.pop_front();
          checkOutput("res_len", bus.res_len, r.len);
          checkOutput("res_gap", bus.res_gap, r.gap);
          checkOutput("len_err", bus.len_err, r.len_err);
          checkOutput("gap_err", bus.gap_err, r.gap_err);
          checkOutput("rec_cnt", bus.rec_cnt, r.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bus.res_ack = 1'b0;
    m_valid     = 1'b0;
    m_overrun   = 1'b0;
    m_cnt       = 0;
    $display("[TB] nominal 9/2, ack every cycle");
    runPhase(0, 1, 0, 6, 0, 100, 1'b0);
    $display("[TB] partial burst at reset release");
    runPhase(4, 1, 0, 5, 0, 50, 1'b0);
    $display("[TB] short bursts 5/2");
    runPhase(2, 2, 1, 5, 0, 60, 1'b0);
    $display("[TB] ack coincident with publish");
    runPhase(0, 1, 0, 5, 0, 0, 1'b1);
    $display("[TB] no ack, overrun, reset mid-burst");
    runPhase(0, 1, 0, 4, 3, 0, 1'b0);
    $display("[TB] saturation 20/3, reset mid-burst");
    runPhase(1, 2, 3, 3, 5, 30, 1'b0);
    for (int k = 0; k < 6; k++) begin
      $display("[TB] random phase %0d", k);
      runPhase($urandom_range(5, 0), $urandom_range(3, 1), 2, 8,
               $urandom_range(4, 0), $urandom_range(100, 0), 1'b0);
    end
    repeat (3) @(negedge clk);
    checkOutput("records_drained", exp_rec.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
